// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one 64-bit memory port between instruction fetch and the
//            load/store unit; one fixed-latency transaction in flight at a time.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [63:0]       if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [31:0]       ls_wdata_i,
    input  logic [3:0]        ls_be_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [31:0]       ls_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [63:0]       mem_wdata_o,
    output logic [7:0]        mem_be_o,
    input  logic [63:0]       mem_rdata_i
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] C_LAT = 3'(MEM_LAT);
    localparam int C_SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [C_SW-1:0] C_STARVE_MAX = C_SW'(STARVE_MAX);

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_owner_ls;
    logic              r_we;
    logic              r_flush_pending;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic [C_SW-1:0]   r_starve;

    logic w_slot;
    logic w_ls_pri;
    logic w_if_gnt;
    logic w_ls_gnt;
    logic w_gnt;
    logic w_resp;

    // The response cycle doubles as an arbitration slot so back-to-back
    // transactions run at one per MEM_LAT cycles.
    assign w_slot   = !reset && ((r_state == IDLE) || (r_cnt == 3'd1));
    assign w_ls_pri = ls_req_i && (r_starve < C_STARVE_MAX);
    assign w_if_gnt = w_slot && if_req_i && !w_ls_pri;
    assign w_ls_gnt = w_slot && ls_req_i && (w_ls_pri || !if_req_i);
    assign w_gnt    = w_if_gnt || w_ls_gnt;
    assign w_resp   = !reset && (r_state == BUSY) && (r_cnt == 3'd1);

    assign if_gnt_o  = w_if_gnt;
    assign ls_gnt_o  = w_ls_gnt;
    assign mem_req_o = w_gnt;

    assign if_rvalid_o = w_resp && !r_owner_ls && !(r_flush_pending || if_flush_i);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 64'h0;
    assign ls_rvalid_o = w_resp && r_owner_ls;
    assign ls_rdata_o  = (ls_rvalid_o && !r_we) ? mem_rdata_i[31:0] : 32'h0;

    // A new grant drives the port directly; otherwise the latched transaction
    // is held until its response cycle.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 64'h0;
        mem_be_o    = 8'h0;
        if (w_ls_gnt) begin
            mem_we_o    = ls_we_i;
            mem_addr_o  = ls_addr_i;
            mem_wdata_o = {32'h0, ls_wdata_i};
            mem_be_o    = {4'h0, ls_be_i};
        end else if (w_if_gnt) begin
            mem_addr_o  = if_addr_i;
        end else if (r_state == BUSY) begin
            mem_we_o    = r_we;
            mem_addr_o  = r_addr;
            mem_wdata_o = {32'h0, r_wdata};
            mem_be_o    = {4'h0, r_be};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_cnt           <= 3'd0;
            r_owner_ls      <= 1'b0;
            r_we            <= 1'b0;
            r_flush_pending <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= 32'h0;
            r_be            <= 4'h0;
            r_starve        <= '0;
        end else begin
            if (w_slot) begin
                if (!if_req_i || w_if_gnt) begin
                    r_starve <= '0;
                end else if (w_ls_gnt && (r_starve != C_STARVE_MAX)) begin
                    r_starve <= r_starve + 1'b1;
                end
            end

            if (w_gnt) begin
                r_state    <= BUSY;
                r_cnt      <= C_LAT;
                r_owner_ls <= w_ls_gnt;
                r_we       <= w_ls_gnt && ls_we_i;
                r_addr     <= w_ls_gnt ? ls_addr_i : if_addr_i;
                r_wdata    <= w_ls_gnt ? ls_wdata_i : 32'h0;
                r_be       <= w_ls_gnt ? ls_be_i : 4'h0;
            end else if (r_state == BUSY) begin
                if (r_cnt == 3'd1) begin
                    r_state <= IDLE;
                    r_cnt   <= 3'd0;
                end else begin
                    r_cnt   <= r_cnt - 3'd1;
                end
            end

            // A flush landing on the grant cycle of a new fetch belongs to it.
            if (w_if_gnt) begin
                r_flush_pending <= if_flush_i;
            end else if (w_resp) begin
                r_flush_pending <= 1'b0;
            end else if ((r_state == BUSY) && !r_owner_ls && if_flush_i) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Randomised scoreboard bench for mem_port_arbiter with a memory
//            macro model and a transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 25;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    logic              clk;
    logic              reset;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [63:0]       if_rdata_o;
    logic              ls_req_i;
    logic              ls_we_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [31:0]       ls_wdata_i;
    logic [3:0]        ls_be_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [31:0]       ls_rdata_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [63:0]       mem_wdata_o;
    logic [7:0]        mem_be_o;
    logic [63:0]       mem_rdata_i;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .ls_req_i    (ls_req_i),
        .ls_we_i     (ls_we_i),
        .ls_addr_i   (ls_addr_i),
        .ls_wdata_i  (ls_wdata_i),
        .ls_be_i     (ls_be_i),
        .ls_gnt_o    (ls_gnt_o),
        .ls_rvalid_o (ls_rvalid_o),
        .ls_rdata_o  (ls_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_rdata_i (mem_rdata_i)
    );

    typedef struct {
        int          due;
        logic [63:0] data;
        logic        flushed;
    } exp_t;

    exp_t        if_q[$];
    exp_t        ls_q[$];
    logic [7:0]  ref_mem[256];
    logic [7:0]  mac_mem[256];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        if_taken = 1'b0;
    logic        ls_taken = 1'b0;
    logic [63:0] last_if_rdata;
    logic [31:0] last_ls_rdata;
    logic        mac_pending = 1'b0;
    int          mac_due = 0;
    logic [63:0] mac_data;

    // Reference model transaction-level state
    logic              m_busy = 1'b0;
    int                m_resp = 0;
    int                m_starve = 0;
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [63:0]       m_wdata;
    logic [7:0]        m_be;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: actual %h required %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_read8(input int ba);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_mem[ba + k];
        return r;
    endfunction

    // Memory macro: captures requests, returns read data MEM_LAT cycles later.
    always @(negedge clk) begin
        int ba;
        if (mem_req_o) begin
            ba = int'(mem_addr_o) * 2;
            if (ba <= 248) begin
                if (mem_we_o) begin
                    for (int k = 0; k < 8; k++)
                        if (mem_be_o[k]) mac_mem[ba + k] = mem_wdata_o[8*k +: 8];
                end
                for (int k = 0; k < 8; k++) mac_data[8*k +: 8] = mac_mem[ba + k];
            end else begin
                mac_data = 64'h0;
            end
            mac_due     = cyc + MEM_LAT;
            mac_pending = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (mac_pending && (mac_due == cyc)) mem_rdata_i = mac_data;
        else mem_rdata_i = {$urandom, $urandom};
    end

    always @(negedge clk) begin
        if_taken = if_gnt_o;
        ls_taken = ls_gnt_o;
    end

    // Reference model: arbitration, port drive and expected responses.
    always @(negedge clk) begin
        logic slot, was_busy, e_if, e_ls;
        exp_t e;
        int ba;
        if (reset) begin
            check("rst_if_gnt", if_gnt_o, 0);
            check("rst_ls_gnt", ls_gnt_o, 0);
            check("rst_mem_req", mem_req_o, 0);
            m_busy   = 1'b0;
            m_starve = 0;
            if_q.delete();
            ls_q.delete();
        end else begin
            was_busy = m_busy;
            slot     = !m_busy || (cyc == m_resp);
            if (m_busy && (cyc == m_resp)) m_busy = 1'b0;
            if (if_flush_i && (if_q.size() > 0)) if_q[0].flushed = 1'b1;

            e_ls = slot && ls_req_i && ((m_starve < STARVE_MAX) || !if_req_i);
            e_if = slot && if_req_i && !e_ls;
            check("if_gnt", if_gnt_o, e_if);
            check("ls_gnt", ls_gnt_o, e_ls);
            check("mem_req", mem_req_o, e_if || e_ls);

            if (slot) begin
                if (!if_req_i || e_if) m_starve = 0;
                else if (e_ls && (m_starve < STARVE_MAX)) m_starve++;
            end

            if (e_if || e_ls) begin
                m_addr  = e_ls ? ls_addr_i : if_addr_i;
                m_we    = e_ls && ls_we_i;
                m_wdata = e_ls ? {32'h0, ls_wdata_i} : 64'h0;
                m_be    = e_ls ? {4'h0, ls_be_i} : 8'h0;
                ba      = int'(m_addr) * 2;
                if (m_we) begin
                    for (int k = 0; k < 4; k++)
                        if (ls_be_i[k]) ref_mem[ba + k] = ls_wdata_i[8*k +: 8];
                end
                e.due     = cyc + MEM_LAT;
                e.flushed = e_if && if_flush_i;
                if (e_ls) begin
                    e.data = m_we ? 64'h0 : {32'h0, ref_read8(ba)[31:0]};
                    ls_q.push_back(e);
                end else begin
                    e.data = ref_read8(ba);
                    if_q.push_back(e);
                end
                m_busy = 1'b1;
                m_resp = cyc + MEM_LAT;
            end else if (!was_busy) begin
                m_addr  = '0;
                m_we    = 1'b0;
                m_wdata = 64'h0;
                m_be    = 8'h0;
            end
            check("mem_addr", mem_addr_o, m_addr);
            check("mem_we", mem_we_o, m_we);
            check("mem_wdata", mem_wdata_o, m_wdata);
            check("mem_be", mem_be_o, m_be);
        end
    end

    // Monitor: pops the scoreboard whenever a response is due.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (reset) begin
            check("rst_if_rvalid", if_rvalid_o, 0);
            check("rst_ls_rvalid", ls_rvalid_o, 0);
        end else begin
            if ((if_q.size() > 0) && (if_q[0].due == cyc)) begin
                e = if_q.pop_front();
                check("if_rvalid", if_rvalid_o, !e.flushed);
                if (!e.flushed && if_rvalid_o) check("if_rdata", if_rdata_o, e.data);
            end else begin
                check("if_rvalid_spurious", if_rvalid_o, 0);
            end
            if (if_rvalid_o) last_if_rdata = if_rdata_o;

            if ((ls_q.size() > 0) && (ls_q[0].due == cyc)) begin
                e = ls_q.pop_front();
                check("ls_rvalid", ls_rvalid_o, 1);
                if (ls_rvalid_o) check("ls_rdata", ls_rdata_o, e.data);
            end else begin
                check("ls_rvalid_spurious", ls_rvalid_o, 0);
            end
            if (ls_rvalid_o) last_ls_rdata = ls_rdata_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drops each request once granted; a request left pending is a failure.
    task automatic wait_all();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_taken) if_req_i = 1'b0;
            if (ls_taken) ls_req_i = 1'b0;
            if (!if_req_i && !ls_req_i) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL grant_timeout @cyc %0d: actual pending required granted", cyc);
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
    endtask

    initial begin
        logic [7:0] init_bytes[12] = '{8'hC1, 8'h11, 8'h5F, 8'h12, 8'h41, 8'h21,
                                       8'hC1, 8'h1E, 8'h0B, 8'h00, 8'hE1, 8'h49};
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = (i < 12) ? init_bytes[i] : 8'($urandom);
            mac_mem[i] = ref_mem[i];
        end
        reset = 1'b1; if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
        ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = 32'h0; ls_be_i = 4'h0;
        mem_rdata_i = 64'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Lone fetch from address 0
        last_if_rdata = 64'h0;
        if_req_i = 1'b1; if_addr_i = 25'd0;
        wait_all();
        repeat (MEM_LAT + 1) tick();
        check("tp_fetch_rdata", last_if_rdata, 64'h1EC1_2141_125F_11C1);

        // Simultaneous fetch and load: load wins first
        last_ls_rdata = 32'h0;
        if_req_i = 1'b1; if_addr_i = 25'd0;
        ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 25'd4; ls_be_i = 4'hF;
        wait_all();
        repeat (2 * MEM_LAT + 1) tick();
        check("tp_load_rdata", last_ls_rdata, 32'h49E1_000B);

        // Both held continuously: starvation guard lets fetch through
        if_req_i = 1'b1; if_addr_i = 25'd8;
        ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 25'd6;
        repeat (12) tick();
        if_req_i = 1'b0; ls_req_i = 1'b0;
        repeat (MEM_LAT + 2) tick();

        // Store, then read it back
        ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 25'h10;
        ls_wdata_i = 32'hDEAD_BEEF; ls_be_i = 4'hF;
        wait_all();
        ls_req_i = 1'b1; ls_we_i = 1'b0;
        wait_all();
        repeat (MEM_LAT + 1) tick();

        // Flushed fetch, then a fresh fetch in its response cycle
        if_req_i = 1'b1; if_addr_i = 25'd8;
        wait_all();
        if_flush_i = 1'b1;
        tick();
        if_flush_i = 1'b0;
        if_req_i = 1'b1; if_addr_i = 25'h20;
        wait_all();
        repeat (MEM_LAT + 1) tick();

        // Reset during an outstanding fetch
        if_req_i = 1'b1; if_addr_i = 25'd0;
        wait_all();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 25'd4;
        wait_all();
        repeat (MEM_LAT + 1) tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
            if_flush_i = ($urandom_range(0, 9) == 0);
            if (if_req_i && if_taken) if_req_i = 1'b0;
            if (!if_req_i) begin
                if ($urandom_range(0, 2) == 0) begin
                    if_req_i  = 1'b1;
                    if_addr_i = 25'($urandom_range(0, 120));
                end
            end else if ($urandom_range(0, 15) == 0) begin
                if_req_i = 1'b0;
            end
            if (ls_req_i && ls_taken) ls_req_i = 1'b0;
            if (!ls_req_i) begin
                if ($urandom_range(0, 2) == 0) begin
                    ls_req_i   = 1'b1;
                    ls_we_i    = 1'($urandom);
                    ls_addr_i  = 25'($urandom_range(0, 120));
                    ls_wdata_i = $urandom;
                    ls_be_i    = 4'($urandom);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                ls_req_i = 1'b0;
            end
        end
        reset = 1'b0; if_req_i = 1'b0; ls_req_i = 1'b0; if_flush_i = 1'b0;
        repeat (MEM_LAT + 3) tick();
        check("if_q_drained", 64'(if_q.size()), 0);
        check("ls_q_drained", 64'(ls_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog @cyc %0d: actual running required finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
